// File: rtl/ex_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_branch_resolve_unit
// Purpose  : EX-stage branch/jump resolution, redirect target generation and
//            misprediction flush sequencing with saturating perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module ex_branch_resolve_unit #(
  parameter int XLEN             = 32,
  parameter int FLUSH_EXT_CYCLES = 4,
  parameter int FLUSH_INT_CYCLES = 6,
  parameter int WARMUP_CYCLES    = 2,
  parameter int CNT_W            = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CACHE_READY,
  input  logic             VALID_EX,
  input  logic             CBRANCH,
  input  logic             JUMP,
  input  logic             JUMPR,
  input  logic             FENCE,
  input  logic             PRIV_JUMP,
  input  logic [XLEN-1:0]  PRIV_JUMP_ADD,
  input  logic [2:0]       FUN3,
  input  logic [XLEN-1:0]  COMP1,
  input  logic [XLEN-1:0]  COMP2,
  input  logic [XLEN-1:0]  JUMP_BUS1,
  input  logic [XLEN-1:0]  JUMP_BUS2,
  input  logic [XLEN-1:0]  PC_EX,
  input  logic [XLEN-1:0]  PC_ID,
  output logic             JUMP_FINAL,
  output logic [XLEN-1:0]  JUMP_ADDR,
  output logic             PREDICTED,
  output logic             FLUSH,
  output logic             FLUSH_I,
  output logic [CNT_W-1:0] BRANCH_COUNT,
  output logic [CNT_W-1:0] MISPRED_COUNT
);

  localparam int C_FC_W = $clog2(FLUSH_INT_CYCLES + 1);
  localparam int C_WU_W = (WARMUP_CYCLES < 1) ? 1 : $clog2(WARMUP_CYCLES + 1);
  localparam logic [C_FC_W-1:0] C_EXT_END  = C_FC_W'(FLUSH_EXT_CYCLES);
  localparam logic [C_FC_W-1:0] C_INT_END  = C_FC_W'(FLUSH_INT_CYCLES);
  localparam logic [C_WU_W-1:0] C_WARM_END = C_WU_W'(WARMUP_CYCLES);
  localparam logic [CNT_W-1:0]  C_CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_FLUSHING = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_flush;
  logic                r_flush_i;
  logic                w_flush_nxt;
  logic                w_flush_i_nxt;
  logic [C_FC_W-1:0]   r_fcnt;
  logic [C_FC_W-1:0]   w_fcnt_nxt;
  logic [C_WU_W-1:0]   r_warm_cnt;
  logic [CNT_W-1:0]    r_branch_cnt;
  logic [CNT_W-1:0]    r_mispred_cnt;

  logic                w_cond;
  logic [XLEN-1:0]     w_pc_plus4;
  logic [XLEN-1:0]     w_bus_sum;
  logic [XLEN-1:0]     w_target;
  logic                w_jump_final;
  logic                w_warm;
  logic                w_mis;
  logic                w_branch_evt;

  always_comb begin
    w_cond = 1'b0;
    case (FUN3)
      3'b000:  w_cond = (COMP1 == COMP2);
      3'b001:  w_cond = (COMP1 != COMP2);
      3'b100:  w_cond = ($signed(COMP1) <  $signed(COMP2));
      3'b101:  w_cond = ($signed(COMP1) >= $signed(COMP2));
      3'b110:  w_cond = (COMP1 <  COMP2);
      3'b111:  w_cond = (COMP1 >= COMP2);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_pc_plus4 = PC_EX + XLEN'(4);
  assign w_bus_sum  = JUMP_BUS1 + JUMP_BUS2;

  // JALR targets are halfword-aligned by clearing bit 0 of the computed sum.
  always_comb begin
    w_target = w_bus_sum;
    if (FENCE)
      w_target = w_pc_plus4;
    else if (PRIV_JUMP)
      w_target = PRIV_JUMP_ADD;
    else if (JUMPR)
      w_target = {w_bus_sum[XLEN-1:1], 1'b0};
  end

  assign w_jump_final = VALID_EX & ~r_flush_i &
                        (FENCE | PRIV_JUMP | (CBRANCH ? w_cond : (JUMP | JUMPR)));

  assign w_warm = (r_warm_cnt == C_WARM_END);

  // A FENCE always refetches, even when ID already holds PC+4.
  assign w_mis = CACHE_READY &
                 ((w_jump_final & ((PC_ID != w_target) | FENCE)) |
                  (VALID_EX & ~r_flush_i & ~w_jump_final & w_warm & (PC_ID != w_pc_plus4)));

  assign w_branch_evt = CACHE_READY & VALID_EX & CBRANCH & ~r_flush_i;

  always_comb begin
    w_state_nxt   = r_state;
    w_flush_nxt   = r_flush;
    w_flush_i_nxt = r_flush_i;
    w_fcnt_nxt    = r_fcnt;
    case (r_state)
      ST_IDLE: begin
        if (w_mis) begin
          w_state_nxt   = ST_FLUSHING;
          w_flush_nxt   = 1'b1;
          w_flush_i_nxt = 1'b1;
          w_fcnt_nxt    = C_FC_W'(1);
        end
      end
      ST_FLUSHING: begin
        w_fcnt_nxt = r_fcnt + C_FC_W'(1);
        if (r_fcnt == C_EXT_END)
          w_flush_nxt = 1'b0;
        if (r_fcnt == C_INT_END) begin
          w_flush_i_nxt = 1'b0;
          w_state_nxt   = ST_IDLE;
          w_fcnt_nxt    = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // All state is frozen while the caches are not ready; reset still wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_flush       <= 1'b0;
      r_flush_i     <= 1'b0;
      r_fcnt        <= '0;
      r_warm_cnt    <= '0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (CACHE_READY) begin
      r_state   <= w_state_nxt;
      r_flush   <= w_flush_nxt;
      r_flush_i <= w_flush_i_nxt;
      r_fcnt    <= w_fcnt_nxt;
      if (!w_warm)
        r_warm_cnt <= r_warm_cnt + C_WU_W'(1);
      if (w_branch_evt && (r_branch_cnt != C_CNT_MAX))
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_mis && (r_mispred_cnt != C_CNT_MAX))
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end
  end

  assign JUMP_FINAL    = w_jump_final;
  assign JUMP_ADDR     = w_target;
  assign PREDICTED     = ~w_mis;
  assign FLUSH         = r_flush;
  assign FLUSH_I       = r_flush_i;
  assign BRANCH_COUNT  = r_branch_cnt;
  assign MISPRED_COUNT = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_branch_resolve_unit
// Purpose  : Directed self-checking bench for ex_branch_resolve_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_branch_resolve_unit;

  logic        CLK;
  logic        RST;
  logic        CACHE_READY;
  logic        VALID_EX;
  logic        CBRANCH;
  logic        JUMP;
  logic        JUMPR;
  logic        FENCE;
  logic        PRIV_JUMP;
  logic [31:0] PRIV_JUMP_ADD;
  logic [2:0]  FUN3;
  logic [31:0] COMP1;
  logic [31:0] COMP2;
  logic [31:0] JUMP_BUS1;
  logic [31:0] JUMP_BUS2;
  logic [31:0] PC_EX;
  logic [31:0] PC_ID;
  logic        JUMP_FINAL;
  logic [31:0] JUMP_ADDR;
  logic        PREDICTED;
  logic        FLUSH;
  logic        FLUSH_I;
  logic [15:0] BRANCH_COUNT;
  logic [15:0] MISPRED_COUNT;

  ex_branch_resolve_unit #(
    .XLEN             (32),
    .FLUSH_EXT_CYCLES (4),
    .FLUSH_INT_CYCLES (6),
    .WARMUP_CYCLES    (2),
    .CNT_W            (16)
  ) u_dut (
    .CLK           (CLK),
    .RST           (RST),
    .CACHE_READY   (CACHE_READY),
    .VALID_EX      (VALID_EX),
    .CBRANCH       (CBRANCH),
    .JUMP          (JUMP),
    .JUMPR         (JUMPR),
    .FENCE         (FENCE),
    .PRIV_JUMP     (PRIV_JUMP),
    .PRIV_JUMP_ADD (PRIV_JUMP_ADD),
    .FUN3          (FUN3),
    .COMP1         (COMP1),
    .COMP2         (COMP2),
    .JUMP_BUS1     (JUMP_BUS1),
    .JUMP_BUS2     (JUMP_BUS2),
    .PC_EX         (PC_EX),
    .PC_ID         (PC_ID),
    .JUMP_FINAL    (JUMP_FINAL),
    .JUMP_ADDR     (JUMP_ADDR),
    .PREDICTED     (PREDICTED),
    .FLUSH         (FLUSH),
    .FLUSH_I       (FLUSH_I),
    .BRANCH_COUNT  (BRANCH_COUNT),
    .MISPRED_COUNT (MISPRED_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef enum int {O_JF, O_ADDR, O_PRED, O_FLUSH, O_FLUSH_I, O_BC, O_MC} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [2:0]  t_f3 [8];
  logic [31:0] t_a  [8];
  logic [31:0] t_b  [8];
  logic        t_tk [8];

  task automatic push(input string tag, input sel_e sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input sel_e s);
    case (s)
      O_JF:      return {31'd0, JUMP_FINAL};
      O_ADDR:    return JUMP_ADDR;
      O_PRED:    return {31'd0, PREDICTED};
      O_FLUSH:   return {31'd0, FLUSH};
      O_FLUSH_I: return {31'd0, FLUSH_I};
      O_BC:      return {16'd0, BRANCH_COUNT};
      default:   return {16'd0, MISPRED_COUNT};
    endcase
  endfunction

  // Inputs change at posedge+1; everything queued for this cycle is checked at the negedge.
  task automatic cycle();
    exp_t        e;
    logic [31:0] obs;
    @(negedge CLK);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_tests++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    CACHE_READY   = 1'b1;
    VALID_EX      = 1'b0;
    CBRANCH       = 1'b0;
    JUMP          = 1'b0;
    JUMPR         = 1'b0;
    FENCE         = 1'b0;
    PRIV_JUMP     = 1'b0;
    PRIV_JUMP_ADD = 32'h0;
    FUN3          = 3'b000;
    COMP1         = 32'h0;
    COMP2         = 32'h0;
    JUMP_BUS1     = 32'h0;
    JUMP_BUS2     = 32'h0;
    PC_EX         = 32'h0;
    PC_ID         = 32'h0;
  endtask

  task automatic drive_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pcex, input logic [31:0] pcid);
    set_idle();
    VALID_EX  = 1'b1;
    CBRANCH   = 1'b1;
    FUN3      = f3;
    COMP1     = a;
    COMP2     = b;
    JUMP_BUS1 = 32'h100;
    JUMP_BUS2 = 32'h20;
    PC_EX     = pcex;
    PC_ID     = pcid;
  endtask

  task automatic drive_jump(input logic j, input logic jr, input logic priv,
                            input logic [31:0] b1, input logic [31:0] b2,
                            input logic [31:0] padd, input logic [31:0] pcid);
    set_idle();
    VALID_EX      = 1'b1;
    JUMP          = j;
    JUMPR         = jr;
    PRIV_JUMP     = priv;
    JUMP_BUS1     = b1;
    JUMP_BUS2     = b2;
    PRIV_JUMP_ADD = padd;
    PC_EX         = 32'h500;
    PC_ID         = pcid;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    set_idle();
    cycle();
    push("rst_flush", O_FLUSH, 32'd0);
    push("rst_flush_i", O_FLUSH_I, 32'd0);
    push("rst_bc", O_BC, 32'd0);
    push("rst_mc", O_MC, 32'd0);
    push("rst_jf", O_JF, 32'd0);
    push("rst_pred", O_PRED, 32'd1);
    cycle();
    RST = 1'b0;
  endtask

  // Six flush cycles with FLUSH high for the first four; inputs are left to the caller.
  task automatic run_flush(input string tag);
    for (int k = 1; k <= 6; k++) begin
      push({tag, "_flush"}, O_FLUSH, (k <= 4) ? 32'd1 : 32'd0);
      push({tag, "_flush_i"}, O_FLUSH_I, 32'd1);
      push({tag, "_jf_gated"}, O_JF, 32'd0);
      push({tag, "_pred"}, O_PRED, 32'd1);
      cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    t_f3[0] = 3'b000; t_a[0] = 32'd5;        t_b[0] = 32'd5;        t_tk[0] = 1'b1;
    t_f3[1] = 3'b001; t_a[1] = 32'd5;        t_b[1] = 32'd5;        t_tk[1] = 1'b0;
    t_f3[2] = 3'b110; t_a[2] = 32'hFFFFFFFF; t_b[2] = 32'd1;        t_tk[2] = 1'b0;
    t_f3[3] = 3'b100; t_a[3] = 32'hFFFFFFFF; t_b[3] = 32'd1;        t_tk[3] = 1'b1;
    t_f3[4] = 3'b101; t_a[4] = 32'hFFFFFFFF; t_b[4] = 32'd1;        t_tk[4] = 1'b0;
    t_f3[5] = 3'b111; t_a[5] = 32'hFFFFFFFF; t_b[5] = 32'd1;        t_tk[5] = 1'b1;
    t_f3[6] = 3'b010; t_a[6] = 32'd7;        t_b[6] = 32'd7;        t_tk[6] = 1'b0;
    t_f3[7] = 3'b011; t_a[7] = 32'd0;        t_b[7] = 32'd0;        t_tk[7] = 1'b0;

    RST = 1'b1;
    set_idle();
    do_reset();

    // Correctly predicted taken BEQ
    drive_branch(3'b000, 32'd5, 32'd5, 32'h11C, 32'h120);
    push("t1_jf", O_JF, 32'd1);
    push("t1_addr", O_ADDR, 32'h120);
    push("t1_pred", O_PRED, 32'd1);
    cycle();
    set_idle();
    push("t1_bc", O_BC, 32'd1);
    push("t1_mc", O_MC, 32'd0);
    push("t1_noflush", O_FLUSH, 32'd0);
    push("t1_noflush_i", O_FLUSH_I, 32'd0);
    cycle();

    // Mispredicted taken BEQ, held during the flush, then re-triggers back-to-back
    drive_branch(3'b000, 32'd5, 32'd5, 32'h11C, 32'h104);
    push("t2_jf", O_JF, 32'd1);
    push("t2_addr", O_ADDR, 32'h120);
    push("t2_pred", O_PRED, 32'd0);
    cycle();
    run_flush("t2");
    push("t2b_flush", O_FLUSH, 32'd0);
    push("t2b_flush_i", O_FLUSH_I, 32'd0);
    push("t2b_jf", O_JF, 32'd1);
    push("t2b_pred", O_PRED, 32'd0);
    push("t2b_bc", O_BC, 32'd2);
    push("t2b_mc", O_MC, 32'd1);
    cycle();

    // Second flush with CACHE_READY low for three cycles: 7 FLUSH, 9 FLUSH_I cycles
    set_idle();
    for (int i = 0; i < 10; i++) begin
      CACHE_READY = !(i >= 2 && i <= 4);
      push("t3_flush", O_FLUSH, (i <= 6) ? 32'd1 : 32'd0);
      push("t3_flush_i", O_FLUSH_I, (i <= 8) ? 32'd1 : 32'd0);
      push("t3_pred", O_PRED, 32'd1);
      cycle();
    end
    CACHE_READY = 1'b1;

    // Branch condition table
    for (int i = 0; i < 8; i++) begin
      drive_branch(t_f3[i], t_a[i], t_b[i], 32'h300, t_tk[i] ? 32'h120 : 32'h304);
      if (i == 0) begin
        push("t4_bc_start", O_BC, 32'd3);
        push("t4_mc_start", O_MC, 32'd2);
      end
      push("t4_cond", O_JF, {31'd0, t_tk[i]});
      push("t4_addr", O_ADDR, 32'h120);
      push("t4_pred", O_PRED, 32'd1);
      cycle();
    end
    set_idle();
    push("t4_bc_end", O_BC, 32'd11);
    push("t4_mc_end", O_MC, 32'd2);
    cycle();

    // Jump target selection
    drive_jump(1'b0, 1'b1, 1'b0, 32'h1001, 32'h0, 32'h0, 32'h1000);
    push("t5_jalr_jf", O_JF, 32'd1);
    push("t5_jalr_addr", O_ADDR, 32'h1000);
    push("t5_jalr_pred", O_PRED, 32'd1);
    cycle();
    drive_jump(1'b1, 1'b0, 1'b0, 32'h1001, 32'h0, 32'h0, 32'h1001);
    push("t5_jal_addr", O_ADDR, 32'h1001);
    push("t5_jal_pred", O_PRED, 32'd1);
    cycle();
    drive_jump(1'b1, 1'b0, 1'b0, 32'hFFFFFFF0, 32'h20, 32'h0, 32'h10);
    push("t5_wrap_addr", O_ADDR, 32'h10);
    push("t5_wrap_pred", O_PRED, 32'd1);
    cycle();
    drive_jump(1'b0, 1'b1, 1'b1, 32'h1001, 32'h0, 32'h80000000, 32'h80000000);
    push("t5_priv_jf", O_JF, 32'd1);
    push("t5_priv_addr", O_ADDR, 32'h80000000);
    push("t5_priv_pred", O_PRED, 32'd1);
    cycle();
    drive_jump(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h504);
    push("t5_seq_jf", O_JF, 32'd0);
    push("t5_seq_pred", O_PRED, 32'd1);
    cycle();
    drive_jump(1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 32'h0, 32'h900);
    VALID_EX = 1'b0;
    push("t5_invalid_jf", O_JF, 32'd0);
    push("t5_invalid_pred", O_PRED, 32'd1);
    push("t5_mc", O_MC, 32'd2);
    cycle();

    // FENCE flushes even though ID already holds PC+4
    set_idle();
    VALID_EX = 1'b1;
    FENCE    = 1'b1;
    PC_EX    = 32'h40;
    PC_ID    = 32'h44;
    push("t6_jf", O_JF, 32'd1);
    push("t6_addr", O_ADDR, 32'h44);
    push("t6_pred", O_PRED, 32'd0);
    cycle();
    set_idle();
    run_flush("t6");
    push("t6_flush_end", O_FLUSH, 32'd0);
    push("t6_flush_i_end", O_FLUSH_I, 32'd0);
    push("t6_mc", O_MC, 32'd3);
    push("t6_bc", O_BC, 32'd11);
    cycle();

    // Fall-through check gated by warm-up, then reset mid-flush
    do_reset();
    set_idle();
    VALID_EX = 1'b1;
    PC_EX    = 32'h200;
    PC_ID    = 32'h300;
    push("t7_warm1_pred", O_PRED, 32'd1);
    push("t7_warm1_jf", O_JF, 32'd0);
    cycle();
    push("t7_warm2_pred", O_PRED, 32'd1);
    push("t7_warm2_flush", O_FLUSH, 32'd0);
    cycle();
    push("t7_warm_pred", O_PRED, 32'd0);
    push("t7_warm_flush", O_FLUSH, 32'd0);
    cycle();
    set_idle();
    push("t7_flush1", O_FLUSH, 32'd1);
    push("t7_flush_i1", O_FLUSH_I, 32'd1);
    push("t7_mc", O_MC, 32'd1);
    push("t7_bc", O_BC, 32'd0);
    cycle();
    RST = 1'b1;
    push("t7_flush2", O_FLUSH, 32'd1);
    push("t7_flush_i2", O_FLUSH_I, 32'd1);
    cycle();
    RST = 1'b0;
    push("t7_rst_flush", O_FLUSH, 32'd0);
    push("t7_rst_flush_i", O_FLUSH_I, 32'd0);
    push("t7_rst_mc", O_MC, 32'd0);
    push("t7_rst_bc", O_BC, 32'd0);
    cycle();
    VALID_EX = 1'b1;
    PC_EX    = 32'h200;
    PC_ID    = 32'h300;
    push("t7_rewarm_pred", O_PRED, 32'd1);
    push("t7_idle_flush", O_FLUSH, 32'd0);
    push("t7_idle_flush_i", O_FLUSH_I, 32'd0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
